onset_controller: RTL and testbench
===================================

Name: onset_controller

Overview:
Sequencing controller wrapped around the SNR-envelope onset detector in the pitch_detect path. It calibrates the noise baseline from the incoming snr_db stream and programs the detector threshold. It then gates the detector's sample strobe and applies a sample-counted refractory window. It also measures inter-onset intervals in audio samples and hands them to the downstream tempo estimator over a valid/ready interface.

Parameters:
SNR_WIDTH, 16, width of snr_db and det_threshold
CAL_LOG2, 8, calibration length = 2^CAL_LOG2 snr samples
THRESH_MARGIN, 3, added to the calibrated mean to form det_threshold
DEFAULT_THRESH, 2, det_threshold value at reset
REFRACT_SAMPLES, 3072, refractory length in snr samples (100 ms at 30720 Hz)
TIMEOUT_SAMPLES, 92160, samples without an onset before interval tracking is dropped (3 s)
INTERVAL_WIDTH, 20, width of the interval counter and output

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; 1 = run, 0 = return to IDLE
recalibrate  in  1  single-cycle pulse; restart calibration
snr_db  in  SNR_WIDTH  SNR sample, unsigned
snr_valid  in  1  snr_db strobe, at most one per cycle
onset_raw  in  1  onset pulse from the detector
det_snr_valid  out  1  gated strobe to the detector
det_threshold  out  SNR_WIDTH  threshold programmed into the detector
state_o  out  2  0=IDLE, 1=CALIBRATE, 2=ARMED, 3=REFRACTORY
interval  out  INTERVAL_WIDTH  inter-onset interval in samples
interval_valid  out  1  interval available
interval_ready  in  1  consumer accepts interval
overrun  out  1  sticky; an interval was dropped because the output was still occupied

Behaviour:
- Reset (async): state IDLE, det_threshold=DEFAULT_THRESH, interval=0, interval_valid=0, overrun=0. All internal counters, accumulator and the have_prev flag cleared.
- det_snr_valid = snr_valid when state is ARMED or REFRACTORY, else 0. This path is combinational with zero latency.
- IDLE: enable=1 -> CALIBRATE next cycle, clearing the accumulator and the sample count.
- CALIBRATE:
  - Each snr_valid adds snr_db to an accumulator of width SNR_WIDTH+CAL_LOG2. No overflow is possible.
  - On the sample that completes 2^CAL_LOG2 samples, det_threshold <= ((acc+snr_db) >> CAL_LOG2) + THRESH_MARGIN, saturated at 2^SNR_WIDTH-1.
  - The state goes to ARMED on the next cycle.
  - det_threshold keeps its previous value until this update.
- ARMED:
  - The interval counter increments on each snr_valid and saturates at 2^INTERVAL_WIDTH-1.
  - onset_raw with have_prev=0: set have_prev, counter <= 0, -> REFRACTORY.
  - onset_raw with have_prev=1: capture the counter value before any same-cycle increment, counter <= 0, -> REFRACTORY.
  - Capture with interval_valid=0: interval <= captured value, interval_valid <= 1.
  - Capture with interval_valid=1 and no transfer this cycle: the value is dropped and overrun <= 1. If a transfer completes in the same cycle, the new value loads instead (no drop).
  - Timeout: when the counter reaches TIMEOUT_SAMPLES with have_prev=1, clear have_prev and the counter. Nothing is output.
- REFRACTORY:
  - Counts snr_valid samples. After REFRACT_SAMPLES samples -> ARMED, and the refractory count resets.
  - onset_raw is ignored.
  - The interval counter and the timeout keep running.
- Handshake: a transfer occurs when interval_valid && interval_ready. interval_valid then drops next cycle unless a capture reloads it. interval stays stable while valid. interval_ready is ignored while interval_valid=0.
- enable=0 in any state -> IDLE next cycle; have_prev and the counters are cleared. A pending interval_valid/interval is kept until transferred. det_threshold is kept.
- recalibrate in ARMED or REFRACTORY -> CALIBRATE, with have_prev, counters and accumulator cleared. In CALIBRATE it restarts the accumulation. In IDLE it is ignored. enable=0 takes priority over recalibrate.
- onset_raw outside ARMED is ignored. overrun clears only on reset.

Test Plan:
1. CAL_LOG2=2, enable=1, snr_db 10,11,12,13 -> det_threshold=14 (mean 11 + 3) one cycle after the 4th sample; state_o 1->2; det_snr_valid=0 throughout calibration.
2. ARMED, REFRACT_SAMPLES=4; onsets 20 samples apart, second onset on a cycle without snr_valid -> first onset gives no output; second gives interval=20, interval_valid=1; onset_raw pulses during the 4 refractory samples produce nothing.
3. interval_ready=0, three onsets 10 and 12 samples apart -> interval=10 held, overrun=1, the 12 is dropped; after interval_ready=1, interval_valid falls the next cycle.
4. Capture on the same cycle as a transfer -> the new interval loads, interval_valid stays 1, overrun stays 0.
5. TIMEOUT_SAMPLES=50, one onset then 50 silent samples, then an onset 30 samples later -> no interval from the timed-out gap; the next interval reported equals the gap after re-priming.
6. Assert reset mid-CALIBRATE, and toggle enable=0 in REFRACTORY -> all outputs return to their reset values; enable=0 gives IDLE next cycle with det_snr_valid=0 and det_threshold retained.

Source files
------------

// File: rtl/onset_controller_if.sv
// Inter-onset interval handoff to the tempo estimator (valid/ready).
interface onset_controller_if #(
  parameter int unsigned INTERVAL_WIDTH = 20
);
  logic [INTERVAL_WIDTH-1:0] interval;
  logic                      interval_valid;
  logic                      interval_ready;

  modport master (
    output interval,
    output interval_valid,
    input  interval_ready
  );

  modport slave (
    input  interval,
    input  interval_valid,
    output interval_ready
  );
endinterface

// File: rtl/onset_controller.sv
// Sequencer around the SNR onset detector: noise calibration, strobe gating,
// refractory window and inter-onset interval measurement.
module onset_controller #(
  parameter int unsigned SNR_WIDTH       = 16,
  parameter int unsigned CAL_LOG2        = 8,
  parameter int unsigned THRESH_MARGIN   = 3,
  parameter int unsigned DEFAULT_THRESH  = 2,
  parameter int unsigned REFRACT_SAMPLES = 3072,
  parameter int unsigned TIMEOUT_SAMPLES = 92160,
  parameter int unsigned INTERVAL_WIDTH  = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 recalibrate,
  input  logic [SNR_WIDTH-1:0] snr_db,
  input  logic                 snr_valid,
  input  logic                 onset_raw,
  output logic                 det_snr_valid,
  output logic [SNR_WIDTH-1:0] det_threshold,
  output logic [1:0]           state_o,
  output logic                 overrun,
  onset_controller_if.master   ivl_if
);

  localparam int unsigned ACC_W  = SNR_WIDTH + CAL_LOG2;
  localparam int unsigned THR_W  = SNR_WIDTH + 1;
  localparam int unsigned REFR_W = $clog2(REFRACT_SAMPLES + 1);

  localparam logic [CAL_LOG2-1:0]       CAL_LAST    = '1;
  localparam logic [INTERVAL_WIDTH-1:0] IVL_MAX     = '1;
  localparam logic [INTERVAL_WIDTH-1:0] TIMEOUT_CNT = INTERVAL_WIDTH'(TIMEOUT_SAMPLES);
  localparam logic [REFR_W-1:0]         REFR_LAST   = REFR_W'(REFRACT_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CAL   = 2'd1,
    ST_ARMED = 2'd2,
    ST_REFR  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic [SNR_WIDTH-1:0]      thresh_q, thresh_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [CAL_LOG2-1:0]       cal_cnt_q, cal_cnt_d;
  logic [INTERVAL_WIDTH-1:0] ivl_cnt_q, ivl_cnt_d;
  logic [REFR_W-1:0]         refr_cnt_q, refr_cnt_d;
  logic                      have_prev_q, have_prev_d;
  logic [INTERVAL_WIDTH-1:0] interval_q, interval_d;
  logic                      ivalid_q, ivalid_d;
  logic                      overrun_q, overrun_d;

  logic [ACC_W-1:0]          sum;
  logic [SNR_WIDTH-1:0]      mean;
  logic [THR_W-1:0]          thr_sum;
  logic [INTERVAL_WIDTH-1:0] ivl_next;
  logic                      timeout;
  logic                      xfer;
  logic                      capture;

  // Calibration arithmetic and free-running interval increment.
  assign sum      = acc_q + ACC_W'(snr_db);
  assign mean     = SNR_WIDTH'(sum >> CAL_LOG2);
  assign thr_sum  = {1'b0, mean} + THR_W'(THRESH_MARGIN);
  assign ivl_next = (snr_valid && (ivl_cnt_q != IVL_MAX)) ? ivl_cnt_q + INTERVAL_WIDTH'(1)
                                                         : ivl_cnt_q;
  assign timeout  = have_prev_q && (ivl_cnt_q >= TIMEOUT_CNT);
  assign xfer     = ivalid_q && ivl_if.interval_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      thresh_q    <= SNR_WIDTH'(DEFAULT_THRESH);
      acc_q       <= '0;
      cal_cnt_q   <= '0;
      ivl_cnt_q   <= '0;
      refr_cnt_q  <= '0;
      have_prev_q <= 1'b0;
      interval_q  <= '0;
      ivalid_q    <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      thresh_q    <= thresh_d;
      acc_q       <= acc_d;
      cal_cnt_q   <= cal_cnt_d;
      ivl_cnt_q   <= ivl_cnt_d;
      refr_cnt_q  <= refr_cnt_d;
      have_prev_q <= have_prev_d;
      interval_q  <= interval_d;
      ivalid_q    <= ivalid_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    thresh_d    = thresh_q;
    acc_d       = acc_q;
    cal_cnt_d   = cal_cnt_q;
    ivl_cnt_d   = ivl_cnt_q;
    refr_cnt_d  = refr_cnt_q;
    have_prev_d = have_prev_q;
    interval_d  = interval_q;
    ivalid_d    = ivalid_q;
    overrun_d   = overrun_q;
    capture     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d   = ST_CAL;
          acc_d     = '0;
          cal_cnt_d = '0;
        end
      end
      ST_CAL: begin
        if (snr_valid) begin
          acc_d     = sum;
          cal_cnt_d = cal_cnt_q + CAL_LOG2'(1);
          if (cal_cnt_q == CAL_LAST) begin
            thresh_d = thr_sum[SNR_WIDTH] ? '1 : thr_sum[SNR_WIDTH-1:0];
            acc_d    = '0;
            state_d  = ST_ARMED;
          end
        end
      end
      ST_ARMED: begin
        ivl_cnt_d = ivl_next;
        if (timeout) begin
          have_prev_d = 1'b0;
          ivl_cnt_d   = '0;
        end
        // A timed-out gap re-primes instead of reporting.
        if (onset_raw) begin
          capture     = have_prev_q && !timeout;
          have_prev_d = 1'b1;
          ivl_cnt_d   = '0;
          refr_cnt_d  = '0;
          state_d     = ST_REFR;
        end
      end
      ST_REFR: begin
        ivl_cnt_d = ivl_next;
        if (timeout) begin
          have_prev_d = 1'b0;
          ivl_cnt_d   = '0;
        end
        if (snr_valid) begin
          if (refr_cnt_q == REFR_LAST) begin
            refr_cnt_d = '0;
            state_d    = ST_ARMED;
          end else begin
            refr_cnt_d = refr_cnt_q + REFR_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Disable wins over recalibrate; both abandon measurement state.
    if (!enable || (recalibrate && (state_q != ST_IDLE))) begin
      state_d     = enable ? ST_CAL : ST_IDLE;
      thresh_d    = thresh_q;
      acc_d       = '0;
      cal_cnt_d   = '0;
      ivl_cnt_d   = '0;
      refr_cnt_d  = '0;
      have_prev_d = 1'b0;
      capture     = 1'b0;
    end

    if (capture) begin
      if (!ivalid_q || xfer) begin
        interval_d = ivl_cnt_q;
        ivalid_d   = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer) begin
      ivalid_d = 1'b0;
    end
  end

  assign det_snr_valid         = snr_valid && ((state_q == ST_ARMED) || (state_q == ST_REFR));
  assign det_threshold         = thresh_q;
  assign state_o               = state_q;
  assign overrun               = overrun_q;
  assign ivl_if.interval       = interval_q;
  assign ivl_if.interval_valid = ivalid_q;

endmodule

// File: tb/tb_onset_controller.sv
// Scoreboard bench for onset_controller: calibration, refractory, handshake,
// overrun, timeout, recalibrate and reset behaviour.
module tb_onset_controller;

  localparam int unsigned SW = 16;
  localparam int unsigned CL = 2;
  localparam int unsigned TM = 3;
  localparam int unsigned DT = 2;
  localparam int unsigned RS = 4;
  localparam int unsigned TO = 50;
  localparam int unsigned IW = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          recalibrate;
  logic [SW-1:0] snr_db;
  logic          snr_valid;
  logic          onset_raw;
  logic          det_snr_valid;
  logic [SW-1:0] det_threshold;
  logic [1:0]    state_o;
  logic          overrun;

  onset_controller_if #(.INTERVAL_WIDTH(IW)) ivl_if ();

  onset_controller #(
    .SNR_WIDTH      (SW),
    .CAL_LOG2       (CL),
    .THRESH_MARGIN  (TM),
    .DEFAULT_THRESH (DT),
    .REFRACT_SAMPLES(RS),
    .TIMEOUT_SAMPLES(TO),
    .INTERVAL_WIDTH (IW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .recalibrate  (recalibrate),
    .snr_db       (snr_db),
    .snr_valid    (snr_valid),
    .onset_raw    (onset_raw),
    .det_snr_valid(det_snr_valid),
    .det_threshold(det_threshold),
    .state_o      (state_o),
    .overrun      (overrun),
    .ivl_if       (ivl_if)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_q[$];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock with the given sample/onset; pulses return low afterwards.
  task automatic step(input logic sv, input logic [SW-1:0] d, input logic on);
    snr_valid = sv;
    snr_db    = d;
    onset_raw = on;
    @(posedge clk);
    #1;
    snr_valid   = 1'b0;
    onset_raw   = 1'b0;
    recalibrate = 1'b0;
  endtask

  task automatic samples(input int n);
    repeat (n) step(1'b1, SW'(7), 1'b0);
  endtask

  task automatic cal_sample(input logic [SW-1:0] d);
    snr_valid = 1'b1;
    snr_db    = d;
    #1;
    chk_eq("cal_det_gate", 32'(det_snr_valid), 32'd0);
    @(posedge clk);
    #1;
    snr_valid   = 1'b0;
    recalibrate = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk_eq("rst_state",    32'(state_o), 32'd0);
    chk_eq("rst_thresh",   32'(det_threshold), 32'(DT));
    chk_eq("rst_interval", 32'(ivl_if.interval), 32'd0);
    chk_eq("rst_ivalid",   32'(ivl_if.interval_valid), 32'd0);
    chk_eq("rst_overrun",  32'(overrun), 32'd0);
  endtask

  // Every completed transfer must match the oldest expected interval.
  always @(negedge clk) begin
    if (!reset && ivl_if.interval_valid && ivl_if.interval_ready) begin
      chk_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk_eq("sb_interval", 32'(ivl_if.interval), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected $finish", $time);
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    recalibrate = 1'b0;
    snr_valid   = 1'b0;
    snr_db      = '0;
    onset_raw   = 1'b0;
    ivl_if.interval_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    reset  = 1'b0;
    enable = 1'b1;

    // Calibration: mean(10..13)=11, +3 -> 14
    step(1'b0, '0, 1'b0);
    chk_eq("cal_enter", 32'(state_o), 32'd1);
    cal_sample(SW'(10));
    cal_sample(SW'(11));
    cal_sample(SW'(12));
    chk_eq("cal_thresh_hold", 32'(det_threshold), 32'(DT));
    chk_eq("cal_state_hold", 32'(state_o), 32'd1);
    cal_sample(SW'(13));
    chk_eq("cal_thresh", 32'(det_threshold), 32'd14);
    chk_eq("cal_armed", 32'(state_o), 32'd2);

    // First onset primes; onsets inside refractory are ignored.
    ivl_if.interval_ready = 1'b1;
    step(1'b0, '0, 1'b1);
    chk_eq("prime_refr", 32'(state_o), 32'd3);
    for (int i = 0; i < int'(RS); i++) begin
      snr_valid = 1'b1;
      onset_raw = 1'b1;
      #1;
      chk_eq("refr_det_gate", 32'(det_snr_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    snr_valid = 1'b0;
    onset_raw = 1'b0;
    chk_eq("refr_exit", 32'(state_o), 32'd2);
    chk_eq("prime_no_out", 32'(ivl_if.interval_valid), 32'd0);
    samples(16);
    exp_q.push_back(20);
    step(1'b0, '0, 1'b1);
    chk_eq("ivl20_valid", 32'(ivl_if.interval_valid), 32'd1);
    chk_eq("ivl20_value", 32'(ivl_if.interval), 32'd20);
    step(1'b0, '0, 1'b0);
    chk_eq("ivl20_drop", 32'(ivl_if.interval_valid), 32'd0);

    // Capture coinciding with a transfer reloads without overrun.
    ivl_if.interval_ready = 1'b0;
    samples(10);
    exp_q.push_back(10);
    step(1'b0, '0, 1'b1);
    chk_eq("hold10_valid", 32'(ivl_if.interval_valid), 32'd1);
    samples(15);
    ivl_if.interval_ready = 1'b1;
    exp_q.push_back(15);
    step(1'b0, '0, 1'b1);
    chk_eq("reload_valid", 32'(ivl_if.interval_valid), 32'd1);
    chk_eq("reload_value", 32'(ivl_if.interval), 32'd15);
    chk_eq("reload_no_ovr", 32'(overrun), 32'd0);
    step(1'b0, '0, 1'b0);
    chk_eq("reload_drain", 32'(ivl_if.interval_valid), 32'd0);

    // Blocked output: 10 held, 12 dropped, overrun sticks.
    ivl_if.interval_ready = 1'b0;
    samples(10);
    exp_q.push_back(10);
    step(1'b0, '0, 1'b1);
    samples(12);
    step(1'b0, '0, 1'b1);
    chk_eq("ovr_flag", 32'(overrun), 32'd1);
    chk_eq("ovr_held", 32'(ivl_if.interval), 32'd10);
    chk_eq("ovr_valid", 32'(ivl_if.interval_valid), 32'd1);
    ivl_if.interval_ready = 1'b1;
    step(1'b0, '0, 1'b0);
    chk_eq("ovr_drain", 32'(ivl_if.interval_valid), 32'd0);
    chk_eq("ovr_sticky", 32'(overrun), 32'd1);

    // Timeout at 50 silent samples; next onset re-primes.
    samples(50);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    chk_eq("to_no_out", 32'(ivl_if.interval_valid), 32'd0);
    samples(30);
    exp_q.push_back(30);
    step(1'b0, '0, 1'b1);
    chk_eq("to_ivl30", 32'(ivl_if.interval), 32'd30);
    samples(49);
    exp_q.push_back(49);
    step(1'b0, '0, 1'b1);
    chk_eq("to_ivl49", 32'(ivl_if.interval), 32'd49);

    // Disable from REFRACTORY.
    enable = 1'b0;
    step(1'b1, SW'(7), 1'b0);
    snr_valid = 1'b1;
    #1;
    chk_eq("dis_idle", 32'(state_o), 32'd0);
    chk_eq("dis_det_gate", 32'(det_snr_valid), 32'd0);
    chk_eq("dis_thresh", 32'(det_threshold), 32'd14);
    snr_valid = 1'b0;

    // Recalibrate inside CALIBRATE discards the partial sum.
    enable = 1'b1;
    step(1'b0, '0, 1'b0);
    cal_sample(SW'(1000));
    cal_sample(SW'(1000));
    recalibrate = 1'b1;
    step(1'b1, SW'(1000), 1'b0);
    chk_eq("recal_cal", 32'(state_o), 32'd1);
    cal_sample(SW'(100));
    cal_sample(SW'(100));
    cal_sample(SW'(100));
    cal_sample(SW'(104));
    chk_eq("recal_thresh", 32'(det_threshold), 32'd104);

    // Recalibrate from ARMED; full-scale input saturates.
    recalibrate = 1'b1;
    step(1'b0, '0, 1'b0);
    chk_eq("recal_armed", 32'(state_o), 32'd1);
    repeat (4) cal_sample(SW'(16'hFFFF));
    chk_eq("sat_thresh", 32'(det_threshold), 32'hFFFF);
    chk_eq("sat_armed", 32'(state_o), 32'd2);

    // Asynchronous reset mid-CALIBRATE.
    recalibrate = 1'b1;
    step(1'b0, '0, 1'b0);
    cal_sample(SW'(5));
    cal_sample(SW'(5));
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, '0, 1'b0);
    chk_eq("post_rst_cal", 32'(state_o), 32'd1);

    chk_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
